// File: rtl/pipe_pkg.sv
// Shared types for the decode->execute stage: control bundle and skid-buffer state encodings.
package pipe_pkg;
  localparam int CTRL_W = 4;

  typedef struct packed {
    logic RegWrite;
    logic MemWrite;
    logic MemToReg;
    logic forward;
  } ctrl_t;

  // Encoded as {skidValid, outValid} so the handshake outputs fall straight out of the state.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;
endpackage

// File: rtl/exec_stage_pipe_if.sv
// Decode/execute stage bundle: valid/ready handshake plus control, ALU function, operands and addresses.
interface exec_stage_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int ALUF_W = 2
) ();
  import pipe_pkg::*;

  logic              valid;
  logic              ready;
  ctrl_t             ctrl;
  logic [ALUF_W-1:0] aluFunc;
  logic [DATA_W-1:0] srcData1;
  logic [DATA_W-1:0] srcData2;
  logic [ADDR_W-1:0] destAdd;
  logic [ADDR_W-1:0] forwardAdd;

  modport master (
    output valid, ctrl, aluFunc, srcData1, srcData2, destAdd, forwardAdd,
    input  ready
  );

  modport slave (
    input  valid, ctrl, aluFunc, srcData1, srcData2, destAdd, forwardAdd,
    output ready
  );
endinterface

// File: rtl/exec_stage_pipe_skid.sv
// Two-entry skid buffer: latency 1, full throughput; inReady is registered (~skid) so
// out_ready never reaches in_ready combinationally. Flush empties both entries.
module skid_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inDat,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outDat
);
  import pipe_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] skidDat;
  logic             take;
  logic             give;

  assign outValid = (state != EMPTY);
  assign inReady  = (state != SKID);
  assign take     = inValid & inReady;
  assign give     = outValid & outReady;

  // Payload registers are zeroed whenever their slot goes empty, so an invalid
  // output never exposes stale control bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      outDat  <= '0;
      skidDat <= '0;
    end else if (flush) begin
      state   <= EMPTY;
      outDat  <= '0;
      skidDat <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (take) begin
            outDat <= inDat;
            state  <= FULL;
          end
        end
        FULL: begin
          if (take && give) begin
            outDat <= inDat;
          end else if (take) begin
            skidDat <= inDat;
            state   <= SKID;
          end else if (give) begin
            outDat <= '0;
            state  <= EMPTY;
          end
        end
        SKID: begin
          if (give) begin
            outDat  <= skidDat;
            skidDat <= '0;
            state   <= FULL;
          end
        end
        default: begin
          state   <= EMPTY;
          outDat  <= '0;
          skidDat <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/exec_stage_pipe.sv
// Decode->execute pipeline register with 2-entry skid buffer and saturating stall counter.
// Latency 1, one entry per clk; upstream stalls only once both entries are held.
module exec_stage_pipe #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int ALUF_W      = 2,
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  exec_stage_pipe_if.slave       up,
  exec_stage_pipe_if.master      dn,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  import pipe_pkg::*;

  localparam int PAY_W = CTRL_W + ALUF_W + 2 * DATA_W + 2 * ADDR_W;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [PAY_W-1:0] inPay;
  logic [PAY_W-1:0] outPay;

  assign inPay = {up.ctrl, up.aluFunc, up.srcData1, up.srcData2, up.destAdd, up.forwardAdd};
  assign {dn.ctrl, dn.aluFunc, dn.srcData1, dn.srcData2, dn.destAdd, dn.forwardAdd} = outPay;

  skid_buf2 #(.WIDTH(PAY_W)) uSkid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .inValid  (up.valid),
    .inReady  (up.ready),
    .inDat    (inPay),
    .outValid (dn.valid),
    .outReady (dn.ready),
    .outDat   (outPay)
  );

  // Performance counter: flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (dn.valid && !dn.ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_exec_stage_pipe.sv
// Bench for exec_stage_pipe: vector table, directed corner sequences, then randomized traffic vs a queue model.
module tb_exec_stage_pipe;
  import pipe_pkg::*;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [1:0]  alu;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [3:0]  dst;
    logic [3:0]  fwd;
  } pay_t;

  typedef struct {
    logic vld;
    logic rdy;
    logic fl;
    pay_t p;
    logic eV;
    logic eR;
    pay_t eP;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [7:0] stall_cnt;
  pay_t       outP;
  int         checks;
  int         failures;

  exec_stage_pipe_if #(.DATA_W(16), .ADDR_W(4), .ALUF_W(2)) upIf ();
  exec_stage_pipe_if #(.DATA_W(16), .ADDR_W(4), .ALUF_W(2)) dnIf ();

  exec_stage_pipe #(.DATA_W(16), .ADDR_W(4), .ALUF_W(2), .STALL_CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .up        (upIf),
    .dn        (dnIf),
    .stall_cnt (stall_cnt)
  );

  assign outP = {dnIf.ctrl, dnIf.aluFunc, dnIf.srcData1, dnIf.srcData2, dnIf.destAdd, dnIf.forwardAdd};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pay_t mk(logic [3:0] c, logic [1:0] a, logic [15:0] s1, logic [15:0] s2,
                              logic [3:0] d, logic [3:0] f);
    pay_t p;
    p.ctrl = c; p.alu = a; p.s1 = s1; p.s2 = s2; p.dst = d; p.fwd = f;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input pay_t p, input logic rdy, input logic fl);
    upIf.valid      = vld;
    upIf.ctrl       = p.ctrl;
    upIf.aluFunc    = p.alu;
    upIf.srcData1   = p.s1;
    upIf.srcData2   = p.s2;
    upIf.destAdd    = p.dst;
    upIf.forwardAdd = p.fwd;
    dnIf.ready      = rdy;
    flush           = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[10];
  pay_t q[$];
  int   mcnt;

  initial begin
    pay_t p1, p2, p3, p4, p5, p6, p7, pa, pb, pc, px, z;
    checks = 0; failures = 0;
    z  = '0;
    p1 = mk(4'b0000, 2'b10, 16'h1234, 16'h0001, 4'h3, 4'h5);
    p2 = mk(4'b1001, 2'b01, 16'hBEEF, 16'h8000, 4'hF, 4'h0);
    p3 = mk(4'b0110, 2'b11, 16'hFFFF, 16'h0000, 4'h1, 4'hE);
    p4 = mk(4'b1111, 2'b00, 16'h0F0F, 16'hA5A5, 4'h7, 4'h8);
    p5 = mk(4'b1000, 2'b01, 16'h5555, 16'h1111, 4'h2, 4'h2);
    p6 = mk(4'b0011, 2'b10, 16'h0001, 16'hFFFE, 4'hA, 4'hB);
    p7 = mk(4'b1100, 2'b11, 16'h7777, 16'h3333, 4'h4, 4'hC);

    //          vld   rdy   fl    in   eV    eR    expected
    tbl[0] = '{1'b1, 1'b1, 1'b0, p1, 1'b1, 1'b1, p1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, p2, 1'b1, 1'b1, p2};
    tbl[2] = '{1'b0, 1'b1, 1'b0, p7, 1'b0, 1'b1, z };
    tbl[3] = '{1'b1, 1'b0, 1'b0, p3, 1'b1, 1'b1, p3};
    tbl[4] = '{1'b1, 1'b0, 1'b0, p4, 1'b1, 1'b0, p3};
    tbl[5] = '{1'b1, 1'b0, 1'b0, p5, 1'b1, 1'b0, p3};
    tbl[6] = '{1'b0, 1'b1, 1'b0, p5, 1'b1, 1'b1, p4};
    tbl[7] = '{1'b1, 1'b1, 1'b0, p6, 1'b1, 1'b1, p6};
    tbl[8] = '{1'b1, 1'b0, 1'b1, p7, 1'b0, 1'b1, z };
    tbl[9] = '{1'b0, 1'b1, 1'b0, p7, 1'b0, 1'b1, z };

    // Reset state
    reset = 1'b1;
    drive(1'b0, z, 1'b0, 1'b0);
    #12;
    chk("reset_out_valid", {63'd0, dnIf.valid}, 64'd0);
    chk("reset_in_ready", {63'd0, upIf.ready}, 64'd1);
    chk("reset_payload", {18'd0, outP}, 64'd0);
    chk("reset_stall_cnt", {56'd0, stall_cnt}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Vector table from empty
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].vld, tbl[i].p, tbl[i].rdy, tbl[i].fl);
      tick();
      chk($sformatf("table_%0d", i), {16'd0, dnIf.valid, upIf.ready, outP},
          {16'd0, tbl[i].eV, tbl[i].eR, tbl[i].eP});
    end

    // A,B,C with downstream stalled, then drained in order
    pa = mk(4'b1010, 2'b01, 16'hAAAA, 16'h0A0A, 4'hA, 4'h1);
    pb = mk(4'b0101, 2'b10, 16'hBBBB, 16'h0B0B, 4'hB, 4'h2);
    pc = mk(4'b1110, 2'b11, 16'hCCCC, 16'h0C0C, 4'hC, 4'h3);
    drive(1'b1, pa, 1'b0, 1'b0); tick();
    chk("abc_main_a", {18'd0, outP}, {18'd0, pa});
    drive(1'b1, pb, 1'b0, 1'b0); tick();
    chk("abc_skid_ready", {63'd0, upIf.ready}, 64'd0);
    drive(1'b1, pc, 1'b0, 1'b0); tick();
    chk("abc_hold_a", {17'd0, upIf.ready, outP}, {17'd0, 1'b0, pa});
    dnIf.ready = 1'b1; tick();
    chk("abc_exit_b", {16'd0, dnIf.valid, upIf.ready, outP}, {16'd0, 1'b1, 1'b1, pb});
    tick();
    chk("abc_exit_c", {16'd0, dnIf.valid, upIf.ready, outP}, {16'd0, 1'b1, 1'b1, pc});
    upIf.valid = 1'b0; tick();
    chk("abc_drained", {63'd0, dnIf.valid}, 64'd0);

    // Flush while SKID holds RegWrite entries; input during flush is dropped
    px = mk(4'b1000, 2'b01, 16'hDEAD, 16'hF00D, 4'h9, 4'h9);
    drive(1'b1, mk(4'b1000, 2'b00, 16'h0101, 16'h0, 4'h1, 4'h0), 1'b0, 1'b0); tick();
    drive(1'b1, mk(4'b1000, 2'b00, 16'h0202, 16'h0, 4'h2, 4'h0), 1'b0, 1'b0); tick();
    chk("flush_pre_skid", {62'd0, dnIf.valid, upIf.ready}, {62'd0, 1'b1, 1'b0});
    drive(1'b1, px, 1'b0, 1'b1); tick();
    chk("flush_state", {61'd0, dnIf.valid, upIf.ready, dnIf.ctrl.RegWrite}, {61'd0, 1'b0, 1'b1, 1'b0});
    chk("flush_payload", {18'd0, outP}, 64'd0);
    drive(1'b0, z, 1'b1, 1'b0); tick();
    chk("flush_dropped", {63'd0, dnIf.valid}, 64'd0);

    // Async reset mid-cycle while in SKID, then latency-1 pass
    drive(1'b1, p4, 1'b0, 1'b0); tick();
    drive(1'b1, p5, 1'b0, 1'b0); tick();
    #3 reset = 1'b1;
    #1;
    chk("async_reset_outs", {16'd0, dnIf.valid, upIf.ready, outP}, {16'd0, 1'b0, 1'b1, z});
    chk("async_reset_cnt", {56'd0, stall_cnt}, 64'd0);
    #2 reset = 1'b0;
    drive(1'b1, p6, 1'b1, 1'b0); tick();
    chk("post_reset_pass", {17'd0, dnIf.valid, outP}, {17'd0, 1'b1, p6});
    upIf.valid = 1'b0; tick();
    chk("post_reset_empty", {63'd0, dnIf.valid}, 64'd0);

    // Stall counter saturation
    drive(1'b1, p1, 1'b0, 1'b0); tick();
    upIf.valid = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("stall_cnt_100", {56'd0, stall_cnt}, 64'd100);
    for (int i = 0; i < 200; i++) tick();
    chk("stall_cnt_sat", {56'd0, stall_cnt}, 64'd255);
    flush = 1'b1; tick(); flush = 1'b0; tick();
    chk("stall_cnt_flush", {55'd0, dnIf.valid, stall_cnt}, {55'd0, 1'b0, 8'd255});

    // Randomized traffic against a 2-deep in-order queue model
    #3 reset = 1'b1;
    #3 reset = 1'b0;
    @(negedge clk);
    q.delete();
    mcnt = 0;
    for (int c = 0; c < 10000; c++) begin
      logic vld, rdy, fl, acc, cons, eV, eR;
      pay_t p, eP;
      vld = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 99) < 3);
      p   = pay_t'({$urandom, $urandom});
      drive(vld, p, rdy, fl);
      acc  = vld && (q.size() < 2);
      cons = (q.size() > 0) && rdy;
      if ((q.size() > 0) && !rdy && (mcnt < 255)) mcnt++;
      if (fl) q.delete();
      else begin
        if (cons) void'(q.pop_front());
        if (acc) q.push_back(p);
      end
      tick();
      eV = (q.size() > 0);
      eR = (q.size() < 2);
      eP = eV ? q[0] : '0;
      chk($sformatf("rand_%0d", c), {8'd0, dnIf.valid, upIf.ready, outP, stall_cnt},
          {8'd0, eV, eR, eP, mcnt[7:0]});
      if (!dnIf.valid)
        chk($sformatf("rand_ctrl_idle_%0d", c), {60'd0, dnIf.ctrl}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
